// File: rtl/uart_host_pkg.sv
// Shared UART register map, IIR interrupt codes and host-agent FSM encoding.
package uart_host_pkg;
    localparam logic [2:0] UART_REG_RB  = 3'd0;
    localparam logic [2:0] UART_REG_TR  = 3'd0;
    localparam logic [2:0] UART_REG_DL1 = 3'd0;
    localparam logic [2:0] UART_REG_DL2 = 3'd1;
    localparam logic [2:0] UART_REG_IE  = 3'd1;
    localparam logic [2:0] UART_REG_II  = 3'd2;
    localparam logic [2:0] UART_REG_FC  = 3'd2;
    localparam logic [2:0] UART_REG_LC  = 3'd3;
    localparam logic [2:0] UART_REG_LS  = 3'd5;
    localparam logic [2:0] UART_REG_MS  = 3'd6;

    // IIR[3:1] interrupt identification codes
    localparam logic [2:0] UART_II_RLS  = 3'b011;
    localparam logic [2:0] UART_II_RDA  = 3'b010;
    localparam logic [2:0] UART_II_TI   = 3'b110;
    localparam logic [2:0] UART_II_THRE = 3'b001;
    localparam logic [2:0] UART_II_MS   = 3'b000;

    localparam int INIT_STEPS = 6;

    typedef logic [3:0] agent_state_t;
    localparam agent_state_t ST_INIT    = 4'd0;
    localparam agent_state_t ST_IDLE    = 4'd1;
    localparam agent_state_t ST_IIR_RD  = 4'd2;
    localparam agent_state_t ST_LSR_RD  = 4'd3;
    localparam agent_state_t ST_RB_RD   = 4'd4;
    localparam agent_state_t ST_RB_WAIT = 4'd5;
    localparam agent_state_t ST_MSR_RD  = 4'd6;
    localparam agent_state_t ST_TX_WR   = 4'd7;
    localparam agent_state_t ST_GAP     = 4'd8;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } init_access_t;
endpackage

// File: rtl/uart_host_init_seq.sv
// Combinational step -> {addr,data} table for the post-reset UART programming sequence.
import uart_host_pkg::*;

module uart_host_init_seq #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_INIT = 8'h03,
    parameter logic [7:0]  FCR_INIT = 8'h06,
    parameter logic [7:0]  IER_INIT = 8'h07
) (
    input  logic [2:0]   step,
    output init_access_t acc
);
    // Divisor latches are only reachable while LCR bit7 (DLAB) is set.
    always_comb begin
        acc = '0;
        case (step)
            3'd0: acc = '{addr: UART_REG_LC,  data: LCR_INIT | 8'h80};
            3'd1: acc = '{addr: UART_REG_DL1, data: DIVISOR[7:0]};
            3'd2: acc = '{addr: UART_REG_DL2, data: DIVISOR[15:8]};
            3'd3: acc = '{addr: UART_REG_LC,  data: LCR_INIT & 8'h7F};
            3'd4: acc = '{addr: UART_REG_FC,  data: FCR_INIT};
            3'd5: acc = '{addr: UART_REG_IE,  data: IER_INIT};
            default: acc = '0;
        endcase
    end
endmodule

// File: rtl/uart_host_agent.sv
// UART bus initiator: programs the UART after reset, services its interrupts and
// streams client bytes into TR under a FIFO credit.
import uart_host_pkg::*;

module uart_host_agent #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_INIT = 8'h03,
    parameter logic [7:0]  FCR_INIT = 8'h06,
    parameter logic [7:0]  IER_INIT = 8'h07,
    parameter int          TX_DEPTH = 16
) (
    input  logic         clk,
    input  logic         wb_rst_i,
    output logic [2:0]   wb_addr_o,
    output logic [7:0]   wb_dat_o,
    input  logic [7:0]   wb_dat_i,
    output logic         wb_we_o,
    output logic         wb_re_o,
    input  logic         int_i,
    input  logic [7:0]   tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [7:0]   rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         init_done,
    output logic [3:0]   err_flags,
    input  logic         err_clr,
    output logic [7:0]   modem_status,
    output agent_state_t fsm_state
);
    // Handshakes: tx byte is taken in the cycle tx_valid && tx_ready (tx_ready is
    // combinational in TX_WR); rx byte is held with rx_valid until rx_valid && rx_ready.
    localparam int CW = $clog2(TX_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(TX_DEPTH);

    agent_state_t state, next_state, gap_ret, next_ret;
    logic [2:0]    init_step;
    logic [CW-1:0] credit;
    init_access_t  init_acc;
    logic          init_last, thre_reload;

    uart_host_init_seq #(
        .DIVISOR (DIVISOR),
        .LCR_INIT(LCR_INIT),
        .FCR_INIT(FCR_INIT),
        .IER_INIT(IER_INIT)
    ) u_init_seq (
        .step(init_step),
        .acc (init_acc)
    );

    assign init_last   = (state == ST_INIT) && (init_step == 3'(INIT_STEPS - 1));
    assign thre_reload = (state == ST_IIR_RD) && !wb_dat_i[0] && (wb_dat_i[3:1] == UART_II_THRE);
    assign fsm_state   = state;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_INIT;
            gap_ret <= ST_IDLE;
        end else begin
            state   <= next_state;
            gap_ret <= next_ret;
        end
    end

    // Every access state is followed by GAP; gap_ret holds where to go after it.
    always_comb begin
        next_state = state;
        next_ret   = gap_ret;
        case (state)
            ST_INIT: begin
                next_state = ST_GAP;
                next_ret   = init_last ? ST_IDLE : ST_INIT;
            end
            ST_IDLE: begin
                if (int_i)                          next_state = ST_IIR_RD;
                else if (tx_valid && credit != '0)  next_state = ST_TX_WR;
            end
            ST_IIR_RD: begin
                next_state = ST_GAP;
                next_ret   = ST_IDLE;
                if (!wb_dat_i[0]) begin
                    case (wb_dat_i[3:1])
                        UART_II_RLS:             next_ret = ST_LSR_RD;
                        UART_II_RDA, UART_II_TI: next_ret = ST_RB_WAIT;
                        UART_II_MS:              next_ret = ST_MSR_RD;
                        default:                 next_ret = ST_IDLE;
                    endcase
                end
            end
            ST_RB_WAIT: if (!rx_valid) next_state = ST_RB_RD;
            ST_LSR_RD, ST_RB_RD, ST_MSR_RD, ST_TX_WR: begin
                next_state = ST_GAP;
                next_ret   = ST_IDLE;
            end
            ST_GAP:  next_state = gap_ret;
            default: next_state = ST_INIT;
        endcase
    end

    // Strobes are gated by reset so an access in flight dies with the reset edge.
    always_comb begin
        wb_addr_o = '0;
        wb_dat_o  = '0;
        wb_we_o   = 1'b0;
        wb_re_o   = 1'b0;
        tx_ready  = 1'b0;
        if (!wb_rst_i) begin
            case (state)
                ST_INIT: begin
                    wb_we_o   = 1'b1;
                    wb_addr_o = init_acc.addr;
                    wb_dat_o  = init_acc.data;
                end
                ST_IIR_RD: begin wb_re_o = 1'b1; wb_addr_o = UART_REG_II; end
                ST_LSR_RD: begin wb_re_o = 1'b1; wb_addr_o = UART_REG_LS; end
                ST_RB_RD:  begin wb_re_o = 1'b1; wb_addr_o = UART_REG_RB; end
                ST_MSR_RD: begin wb_re_o = 1'b1; wb_addr_o = UART_REG_MS; end
                ST_TX_WR: begin
                    wb_we_o   = 1'b1;
                    wb_addr_o = UART_REG_TR;
                    wb_dat_o  = tx_data;
                    tx_ready  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            init_step    <= '0;
            init_done    <= 1'b0;
            credit       <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            err_flags    <= '0;
            modem_status <= '0;
        end else begin
            if (state == ST_INIT && !init_last) init_step <= init_step + 3'd1;
            if (init_last) init_done <= 1'b1;
            // THRE means the UART FIFO is empty, so the full depth is available again.
            if (init_last || thre_reload)
                credit <= CREDIT_FULL;
            else if (state == ST_TX_WR && credit != '0)
                credit <= credit - CW'(1);
            if (state == ST_RB_RD) begin
                rx_data  <= wb_dat_i;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
            err_flags <= (err_clr ? 4'b0000 : err_flags)
                       | ((state == ST_LSR_RD) ? wb_dat_i[4:1] : 4'b0000);
            if (state == ST_MSR_RD) modem_status <= wb_dat_i;
        end
    end
endmodule

// File: tb/tb_uart_host_agent.sv
// Bench for uart_host_agent: behavioural UART register-file target plus directed and random traffic.
module tb_uart_host_agent;
  import uart_host_pkg::*;

  logic clk = 1'b0;
  logic wb_rst_i = 1'b1;
  logic [2:0] wb_addr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic wb_we_o, wb_re_o, int_i;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0, tx_ready;
  logic [7:0] rx_data;
  logic rx_valid, rx_ready = 1'b0;
  logic init_done;
  logic [3:0] err_flags;
  logic err_clr = 1'b0;
  logic [7:0] modem_status;
  agent_state_t fsm_state;

  uart_host_agent dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_re_o(wb_re_o), .int_i(int_i),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .init_done(init_done),
    .err_flags(err_flags), .err_clr(err_clr), .modem_status(modem_status),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // target model state and test requests
  typedef struct { logic we; logic [2:0] addr; logic [7:0] data; int cyc; } acc_t;
  acc_t acc_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_head = 8'h00, msr_val = 8'h00;
  logic rx_ne = 1'b0, thre_pend = 1'b0, ms_pend = 1'b0, dlab = 1'b0, prev_strobe = 1'b0;
  logic [3:0] lsr_err = 4'h0, iir;
  logic [2:0] drain_tick = 3'd0;
  int tx_cnt = 0, cyc = 0, viol = 0, overflow = 0, rb_reads = 0, iir_reads = 0;
  logic inj_rx = 0, inj_lsr = 0, inj_ms = 0, inj_thre = 0, drain_en = 0, loopback = 0;
  logic [7:0] inj_byte = 8'h00, inj_msr = 8'h00;
  logic [3:0] inj_err = 4'h0;

  always_comb begin
    if (lsr_err != 4'h0) iir = 4'b0110;
    else if (rx_ne)      iir = 4'b0100;
    else if (thre_pend)  iir = 4'b0010;
    else if (ms_pend)    iir = 4'b0000;
    else                 iir = 4'b0001;
  end
  assign int_i = ~iir[0];

  always_comb begin
    wb_dat_i = 8'h00;
    if (wb_re_o) begin
      case (wb_addr_o)
        3'd0: wb_dat_i = rx_head;
        3'd2: wb_dat_i = {4'hC, iir};
        3'd5: wb_dat_i = {3'b011, lsr_err, rx_ne};
        3'd6: wb_dat_i = msr_val;
        default: wb_dat_i = 8'h00;
      endcase
    end
  end

  always @(posedge clk) begin
    logic [3:0] le;
    logic tp, mp;
    int tc;
    acc_t a;
    le = lsr_err; tp = thre_pend; mp = ms_pend; tc = tx_cnt;
    cyc <= cyc + 1;
    drain_tick <= drain_tick + 3'd1;
    if (drain_en && tc > 0 && drain_tick == 3'd7) begin
      tc = tc - 1;
      if (tc == 0) tp = 1'b1;
    end
    if (wb_we_o && wb_re_o) viol <= viol + 1;
    else if ((wb_we_o || wb_re_o) && prev_strobe) viol <= viol + 1;
    prev_strobe <= wb_we_o || wb_re_o;
    if (wb_we_o || wb_re_o) begin
      a.we = wb_we_o; a.addr = wb_addr_o; a.cyc = cyc;
      a.data = wb_we_o ? wb_dat_o : wb_dat_i;
      acc_q.push_back(a);
    end
    if (wb_we_o) begin
      case (wb_addr_o)
        3'd0: if (!dlab) begin
          tx_log.push_back(wb_dat_o);
          tc = tc + 1;
          tp = 1'b0;
          if (tc > 16) overflow <= overflow + 1;
          if (loopback) rx_q.push_back(wb_dat_o);
        end
        3'd2: if (wb_dat_o[2]) tc = 0;
        3'd3: dlab <= wb_dat_o[7];
        default: ;
      endcase
    end
    if (wb_re_o) begin
      case (wb_addr_o)
        3'd0: if (!dlab) begin
          rb_reads <= rb_reads + 1;
          if (rx_q.size() != 0) void'(rx_q.pop_front());
        end
        3'd2: begin
          iir_reads <= iir_reads + 1;
          if (iir == 4'b0010) tp = 1'b0;
        end
        3'd5: le = 4'h0;
        3'd6: mp = 1'b0;
        default: ;
      endcase
    end
    if (inj_rx) rx_q.push_back(inj_byte);
    if (inj_lsr) le = le | inj_err;
    if (inj_ms) begin mp = 1'b1; msr_val <= inj_msr; end
    if (inj_thre) begin tc = 0; tp = 1'b1; end
    lsr_err <= le; thre_pend <= tp; ms_pend <= mp; tx_cnt <= tc;
    rx_ne <= (rx_q.size() != 0);
    rx_head <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  // scoreboard / counters
  int checks = 0, passed = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    $display("FAIL %s: got no event expected one within bound", name);
  endtask

  // driver tasks (called at a negedge)
  task automatic pulse_inject(input int kind, input logic [7:0] v);
    case (kind)
      0: begin inj_rx = 1'b1; inj_byte = v; end
      1: begin inj_lsr = 1'b1; inj_err = v[3:0]; end
      2: begin inj_ms = 1'b1; inj_msr = v; end
      default: inj_thre = 1'b1;
    endcase
    @(negedge clk);
    inj_rx = 1'b0; inj_lsr = 1'b0; inj_ms = 1'b0; inj_thre = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget && acc_q.size() < n; i++) @(negedge clk);
    if (acc_q.size() < n) fail_timeout(name);
  endtask

  task automatic wait_rx_valid(input int budget, input string name);
    int i;
    for (i = 0; i < budget && !rx_valid; i++) @(negedge clk);
    if (!rx_valid) fail_timeout(name);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    tx_valid = 1'b0;
    if (!ok) fail_timeout("tx_ready");
  endtask

  task automatic accept_rx();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct { logic [2:0] addr; logic [7:0] data; } init_vec_t;
  typedef struct { int kind; logic [7:0] val; logic [2:0] exp_addr; } disp_vec_t;
  init_vec_t init_tab[6];
  disp_vec_t disp_tab[5];

  initial begin
    int mark, mark_tx, iir0, rb0, sent_cnt, n_rand;
    logic [3:0] exp_err;
    init_tab[0] = '{3'd3, 8'h83}; init_tab[1] = '{3'd0, 8'h1B};
    init_tab[2] = '{3'd1, 8'h00}; init_tab[3] = '{3'd3, 8'h03};
    init_tab[4] = '{3'd2, 8'h06}; init_tab[5] = '{3'd1, 8'h07};
    disp_tab[0] = '{0, 8'h3C, 3'd0}; disp_tab[1] = '{1, 8'h04, 3'd5};
    disp_tab[2] = '{2, 8'hB7, 3'd6}; disp_tab[3] = '{1, 8'h09, 3'd5};
    disp_tab[4] = '{0, 8'hC3, 3'd0};
    exp_err = 4'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", {wb_we_o, wb_re_o, tx_ready}, 0);
    check("rst_outputs", {rx_valid, init_done, err_flags, modem_status, rx_data}, 0);

    // init sequence
    mark = acc_q.size();
    wb_rst_i = 1'b0;
    wait_acc(mark + 6, 40, "init_accesses");
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (acc_q.size() > mark + i) begin
        check($sformatf("init_w%0d", i), {acc_q[mark+i].we, acc_q[mark+i].addr, acc_q[mark+i].data},
              {1'b1, init_tab[i].addr, init_tab[i].data});
        if (i > 0) check($sformatf("init_gap%0d", i), acc_q[mark+i].cyc - acc_q[mark+i-1].cyc, 2);
      end
    end
    check("init_done", init_done, 1);

    // interrupt dispatch table
    for (int i = 0; i < 5; i++) begin
      mark = acc_q.size();
      pulse_inject(disp_tab[i].kind, disp_tab[i].val);
      wait_acc(mark + 2, 40, "disp_access");
      if (acc_q.size() >= mark + 2) begin
        check($sformatf("disp%0d_iir", i), {acc_q[mark].we, acc_q[mark].addr}, {1'b0, 3'd2});
        check($sformatf("disp%0d_addr", i), {acc_q[mark+1].we, acc_q[mark+1].addr}, {1'b0, disp_tab[i].exp_addr});
      end
      case (disp_tab[i].kind)
        0: begin
          check($sformatf("disp%0d_rx", i), {rx_valid, rx_data}, {1'b1, disp_tab[i].val});
          accept_rx();
          check($sformatf("disp%0d_rx_drop", i), rx_valid, 0);
        end
        1: begin
          exp_err = exp_err | disp_tab[i].val[3:0];
          check($sformatf("disp%0d_err", i), err_flags, exp_err);
        end
        default: check($sformatf("disp%0d_msr", i), modem_status, disp_tab[i].val);
      endcase
    end

    // err_clr held across a new error: set wins, old bits cleared
    err_clr = 1'b1;
    mark = acc_q.size();
    pulse_inject(1, 8'h02);
    wait_acc(mark + 2, 40, "setwins_access");
    check("err_set_wins", err_flags, 4'b0010);
    err_clr = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", err_flags, 0);

    // loopback byte A5
    loopback = 1'b1;
    rb0 = rb_reads;
    send_byte(8'hA5);
    wait_rx_valid(40, "loop_rx_valid");
    check("loop_rx_data", rx_data, 8'hA5);
    repeat (5) @(negedge clk);
    check("loop_rx_hold", rx_valid, 1);
    check("loop_rb_once", rb_reads - rb0, 1);
    accept_rx();
    check("loop_rx_drop", rx_valid, 0);
    loopback = 1'b0;

    // 17 back-to-back bytes against a 16-deep credit
    pulse_inject(3, 8'h00);
    repeat (10) @(negedge clk);
    mark_tx = tx_log.size();
    sent_cnt = 0;
    iir0 = iir_reads;
    fork
      begin
        for (int i = 0; i < 17; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          exp_q.push_back(b);
          send_byte(b);
          sent_cnt++;
        end
      end
      begin
        repeat (150) @(negedge clk);
        check("stall_writes", tx_log.size() - mark_tx, 16);
        check("stall_ready", sent_cnt, 16);
        iir0 = iir_reads;
        pulse_inject(3, 8'h00);
      end
    join
    check("tx17_writes", tx_log.size() - mark_tx, 17);
    check("tx17_iir_first", iir_reads > iir0, 1);
    for (int i = 0; i < 17; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (tx_log.size() > mark_tx + i) check($sformatf("tx17_b%0d", i), tx_log[mark_tx+i], e);
    end

    // two bytes arriving while the consumer stalls
    rb0 = rb_reads;
    pulse_inject(0, 8'h11);
    pulse_inject(0, 8'h22);
    repeat (30) @(negedge clk);
    check("stall2_first", {rx_valid, rx_data}, {1'b1, 8'h11});
    check("stall2_one_rb", rb_reads - rb0, 1);
    accept_rx();
    wait_rx_valid(40, "stall2_second_valid");
    check("stall2_second", rx_data, 8'h22);
    check("stall2_two_rb", rb_reads - rb0, 2);
    accept_rx();

    // random loopback stream checked against the tx order
    loopback = 1'b1;
    drain_en = 1'b1;
    n_rand = 40;
    fork
      begin
        for (int i = 0; i < n_rand; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          exp_q.push_back(b);
          send_byte(b);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        int got = 0;
        for (int t = 0; t < 6000 && got < n_rand; t++) begin
          logic r;
          logic [7:0] e;
          @(negedge clk);
          r = 1'($urandom_range(0, 1));
          rx_ready = r;
          if (rx_valid && r) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            check($sformatf("rand_rx%0d", got), rx_data, e);
            got++;
          end
        end
        rx_ready = 1'b0;
        if (got < n_rand) fail_timeout("rand_rx_stream");
      end
    join
    loopback = 1'b0;
    drain_en = 1'b0;
    check("bus_protocol", viol, 0);
    check("tx_overflow", overflow, 0);

    // reset during a TR write
    pulse_inject(3, 8'h00);
    repeat (10) @(negedge clk);
    mark_tx = tx_log.size();
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    for (int i = 0; i < 50 && !(wb_we_o && wb_addr_o == 3'd0); i++) @(negedge clk);
    if (!(wb_we_o && wb_addr_o == 3'd0)) fail_timeout("rst_tx_wr");
    #1 wb_rst_i = 1'b1;
    #1;
    check("rst_mid_strobes", {wb_we_o, wb_re_o, tx_ready}, 0);
    check("rst_mid_outputs", {init_done, modem_status}, 0);
    tx_valid = 1'b0;
    mark = acc_q.size();
    @(negedge clk);
    check("rst_mid_no_tr", tx_log.size() - mark_tx, 0);
    wb_rst_i = 1'b0;
    wait_acc(mark + 2, 20, "reinit_accesses");
    if (acc_q.size() >= mark + 2) begin
      check("reinit_w0", {acc_q[mark].we, acc_q[mark].addr, acc_q[mark].data}, {1'b1, 3'd3, 8'h83});
      check("reinit_w1", {acc_q[mark+1].we, acc_q[mark+1].addr, acc_q[mark+1].data}, {1'b1, 3'd0, 8'h1B});
    end

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
